pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
- Downstream of the sprite drawers (player, bullet, alien blocks).
- Collects per-pixel write requests (x, y, colour) from several drawers over a valid/ready handshake and grants one per cycle, round-robin.
- Drives the single pixel-write port of the VGA adapter: x, y, colour, plot.
- Also runs a full-screen clear sweep on request, and drops off-screen coordinates, such as those produced by a bullet leaving the top edge.

Parameters:
- N_SRC, 4, number of requesting drawers (2..8).
- SCREEN_W, 320, visible width; valid x is 0..SCREEN_W-1.
- SCREEN_H, 240, visible height; valid y is 0..SCREEN_H-1.
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N_SRC  per-source pixel request valid
- req_x  input  9*N_SRC  packed x, source i at [9i+8:9i]
- req_y  input  8*N_SRC  packed y, source i at [8i+7:8i]
- req_colour  input  3*N_SRC  packed colour, source i at [3i+2:3i]
- req_ready  output  N_SRC  one-hot grant; transfer when valid&ready
- clear_req  input  1  single-cycle request to clear screen
- busy  output  1  high while in CLEAR
- clear_done  output  1  one-cycle pulse after last clear pixel
- x  output  9  pixel x to VGA adapter
- y  output  8  pixel y to VGA adapter
- colour  output  3  pixel colour to VGA adapter
- plot  output  1  write enable to VGA adapter, one cycle per pixel
- drop_count  output  8  saturating count of dropped off-screen pixels

Behaviour:
Reset:
- On reset assertion, immediately: state=ARB; x, y, colour, plot, busy, clear_done, drop_count = 0; rr pointer = 0.
- req_ready is forced to 0 while reset is high.

States:
- ARB:
  - req_ready is combinational.
  - Grant goes to the first source with valid=1, searching from index rr_ptr+1 upward and wrapping modulo N_SRC.
  - At most one bit of req_ready is high; it is 0 if no source is valid.
  - On transfer, rr_ptr is set to the granted index.
  - On the next clock edge, x/y/colour are registered from the granted source.
  - plot=1 for exactly one cycle if x<SCREEN_W and y<SCREEN_H. Otherwise plot=0 and drop_count increments, saturating at 255.
  - Latency from handshake to plot is 1 cycle; throughput is 1 pixel/cycle.
  - clear_req=1 in ARB: move to CLEAR on the next edge.
    - req_ready=0 in that same cycle; clear takes priority over any pending request.
    - Sweep counters load (0,0).
- CLEAR:
  - busy=1 and req_ready=0.
  - Each cycle: plot=1, x/y = sweep counters, colour=CLEAR_COLOUR.
  - Sweep x increments each cycle. At x=SCREEN_W-1 it wraps to 0 and y increments.
  - After plotting (SCREEN_W-1, SCREEN_H-1): clear_done=1 for one cycle, busy=0, return to ARB.
  - Sweep length is exactly SCREEN_W*SCREEN_H cycles.
  - clear_req during CLEAR is ignored; it is not queued.

Handshake and other rules:
- Sources must hold x/y/colour stable while valid=1 and ready=0.
- A source may drop valid without a transfer; no state changes.
- plot is low in any cycle without a registered on-screen pixel or clear write.
- x/y/colour hold their last values when plot=0.
- Reset mid-clear aborts the sweep; clear_done is not pulsed.
- Width rules:
  - Bounds comparisons are unsigned at full 9/8-bit width.
  - Wrapped negative coordinates, e.g. y=8'd254 from an underflowing subtract, are out of range and dropped.

Test Plan:
- Reset then idle: all req_valid=0 -> plot=0, req_ready=0, drop_count=0 for 20 cycles.
- Single source: source 1 valid with (100,50,3'b001) -> req_ready=4'b0010 same cycle; next cycle plot=1, x=100, y=50, colour=001.
- Round-robin: all 4 valid continuously, rr_ptr=0 after reset -> grants in order 1,2,3,0,1,... with plot every cycle and no gaps.
- Off-screen drop:
  - source 0 sends (320,10) -> plot stays 0, drop_count=1;
  - source 0 sends (5,254) -> drop_count=2;
  - 300 further drops -> drop_count saturates at 255.
- Clear sweep:
  - clear_req pulse with sources valid -> req_ready=0 throughout.
  - 76800 consecutive plot cycles with colour=000.
  - First pixel (0,0), pixel 320 is (0,1), last is (319,239).
  - clear_done pulses once; arbitration resumes the next cycle.
- Reset mid-clear: assert reset at sweep pixel 1000 -> plot, busy, x, y go 0 immediately; after release state=ARB, clear_done never pulsed, source grants resume.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter for sprite-drawer pixel writes onto the single VGA plot port.
// Also sweeps the whole screen with CLEAR_COLOUR on request and drops off-screen pixels.
module pixel_write_arbiter #(
    parameter int         N_SRC        = 4,
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     req_valid,
    input  logic [9*N_SRC-1:0]   req_x,
    input  logic [8*N_SRC-1:0]   req_y,
    input  logic [3*N_SRC-1:0]   req_colour,
    output logic [N_SRC-1:0]     req_ready,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_done,
    output logic [8:0]           x,
    output logic [7:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic [7:0]           drop_count
);
    localparam int         PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [8:0] LAST_X = 9'(SCREEN_W - 1);
    localparam logic [7:0] LAST_Y = 8'(SCREEN_H - 1);

    typedef enum logic {S_ARB, S_CLEAR} state_t;

    state_t           r_state, w_state_nxt;
    logic [PTR_W-1:0] r_rr;
    logic [8:0]       r_x;
    logic [7:0]       r_y;
    logic [2:0]       r_colour;
    logic             r_plot, r_clear_done;
    logic [7:0]       r_drop;

    logic [PTR_W-1:0] w_cand, w_gidx;
    logic             w_found, w_xfer, w_on, w_sweep_last;
    logic [8:0]       w_gx;
    logic [7:0]       w_gy;
    logic [2:0]       w_gc;

    assign w_gx = req_x[9*int'(w_gidx) +: 9];
    assign w_gy = req_y[8*int'(w_gidx) +: 8];
    assign w_gc = req_colour[3*int'(w_gidx) +: 3];
    // Full-width unsigned bounds: wrapped negatives like y=254 land out of range.
    assign w_on = ({1'b0, w_gx} < 10'(SCREEN_W)) && ({1'b0, w_gy} < 9'(SCREEN_H));
    assign w_sweep_last = (r_x == LAST_X) && (r_y == LAST_Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_ARB;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand      = '0;
        w_gidx      = '0;
        w_found     = 1'b0;
        w_xfer      = 1'b0;
        req_ready   = '0;
        // Search starts just past the last winner, so it ends up lowest priority.
        for (int i = 1; i <= N_SRC; i++) begin
            w_cand = PTR_W'((int'(r_rr) + i) % N_SRC);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
        case (r_state)
            S_ARB: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_found && !reset) begin
                    w_xfer            = 1'b1;
                    req_ready[w_gidx] = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_sweep_last) w_state_nxt = S_ARB;
            end
            default: w_state_nxt = S_ARB;
        endcase
    end

    // In CLEAR the output x/y registers double as the sweep counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_plot       <= 1'b0;
            r_clear_done <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_plot       <= 1'b0;
            r_clear_done <= 1'b0;
            case (r_state)
                S_ARB: begin
                    if (clear_req) begin
                        r_x      <= '0;
                        r_y      <= '0;
                        r_colour <= CLEAR_COLOUR;
                        r_plot   <= 1'b1;
                    end else if (w_xfer) begin
                        r_rr <= w_gidx;
                        if (w_on) begin
                            r_x      <= w_gx;
                            r_y      <= w_gy;
                            r_colour <= w_gc;
                            r_plot   <= 1'b1;
                        end else if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (w_sweep_last) begin
                        r_clear_done <= 1'b1;
                    end else begin
                        r_plot <= 1'b1;
                        if (r_x == LAST_X) begin
                            r_x <= '0;
                            r_y <= r_y + 8'd1;
                        end else begin
                            r_x <= r_x + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state == S_CLEAR);
    assign clear_done = r_clear_done;
    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomised bench for pixel_write_arbiter: arbitration, drops, clear sweep and reset abort
// are checked against a simple round-robin/bounds reference model.
module tb_pixel_write_arbiter;
    logic        clk, reset;
    logic [3:0]  req_valid, req_ready;
    logic [35:0] req_x;
    logic [31:0] req_y;
    logic [11:0] req_colour;
    logic        clear_req, busy, clear_done, plot;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic [7:0]  drop_count;

    int total = 0, bad = 0;
    int m_rr = 0;
    int m_drop = 0;
    logic [8:0] m_x;
    logic [7:0] m_y;
    logic [2:0] m_c;
    logic [8:0] sx[4];
    logic [7:0] sy[4];
    logic [2:0] sc[4];

    pixel_write_arbiter #(.N_SRC(4), .SCREEN_W(320), .SCREEN_H(240), .CLEAR_COLOUR(3'b000)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .req_ready(req_ready), .clear_req(clear_req), .busy(busy),
        .clear_done(clear_done), .x(x), .y(y), .colour(colour), .plot(plot), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] v);
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_x[9*i +: 9]      = sx[i];
            req_y[8*i +: 8]      = sy[i];
            req_colour[3*i +: 3] = sc[i];
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int rr);
        for (int k = 1; k <= 4; k++)
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] r;
        r = 4'b0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_rr = 0; m_drop = 0; m_x = 0; m_y = 0; m_c = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin sx[i] = 9'd10; sy[i] = 8'd10; sc[i] = 3'd1; end
        apply(4'hF);
        tick(); tick();
        total++;
        if ({plot, busy, clear_done, x, y, colour, drop_count, req_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d drop=%0d ready=%b, want all 0",
                     plot, busy, clear_done, x, y, colour, drop_count, req_ready);
        end
        apply(4'h0);
        reset = 1'b0;
        m_rr = 0; m_drop = 0; m_x = 0; m_y = 0; m_c = 0;
        for (int n = 0; n < 20; n++) begin
            total++;
            if ({plot, req_ready, drop_count} !== '0) begin
                bad++;
                $display("FAIL idle cycle %0d: plot=%b ready=%b drop=%0d, want 0/0000/0", n, plot, req_ready, drop_count);
            end
            tick();
        end
    endtask

    task automatic test_single();
        sx[1] = 9'd100; sy[1] = 8'd50; sc[1] = 3'b001;
        apply(4'b0010);
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL single_ready: got %b want 0010", req_ready);
        end
        tick();
        apply(4'b0000);
        total++;
        if ({plot, x, y, colour} !== {1'b1, 9'd100, 8'd50, 3'b001}) begin
            bad++; $display("FAIL single_plot: plot=%b x=%0d y=%0d c=%b want 1/100/50/001", plot, x, y, colour);
        end
        tick();
        total++;
        if (plot !== 1'b0) begin
            bad++; $display("FAIL single_plot_width: plot=%b want 0", plot);
        end
        m_rr = 1;
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sx[i] = 9'($urandom_range(0, 319)); sy[i] = 8'($urandom_range(0, 239)); sc[i] = 3'($urandom);
        end
        for (int n = 0; n < 12; n++) begin
            apply(4'hF);
            #1;
            g = (n + 1) % 4;
            total++;
            if (req_ready !== onehot(g)) begin
                bad++; $display("FAIL rr_grant %0d: got %b want %b", n, req_ready, onehot(g));
            end
            tick();
            total++;
            if ({plot, x, y, colour} !== {1'b1, sx[g], sy[g], sc[g]}) begin
                bad++; $display("FAIL rr_plot %0d: plot=%b x=%0d y=%0d c=%0d want 1/%0d/%0d/%0d",
                                n, plot, x, y, colour, sx[g], sy[g], sc[g]);
            end
            m_rr = g;
            sx[g] = 9'($urandom_range(0, 319)); sy[g] = 8'($urandom_range(0, 239)); sc[g] = 3'($urandom);
        end
        apply(4'h0);
    endtask

    task automatic test_random();
        logic [3:0] v, prev_v;
        logic       exp_plot;
        int         g;
        do_reset();
        prev_v = 4'h0;
        g = -1;
        for (int n = 0; n < 300; n++) begin
            v = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (!prev_v[i] || i == g) begin
                    sx[i] = 9'($urandom_range(0, 330)); sy[i] = 8'($urandom_range(0, 255)); sc[i] = 3'($urandom);
                end
            end
            apply(v);
            #1;
            g = model_grant(v, m_rr);
            total++;
            if (req_ready !== onehot(g)) begin
                bad++; $display("FAIL rand_grant %0d: valid=%b got %b want %b", n, v, req_ready, onehot(g));
            end
            tick();
            exp_plot = 1'b0;
            if (g >= 0) begin
                m_rr = g;
                if (sx[g] < 9'd320 && sy[g] < 8'd240) begin
                    exp_plot = 1'b1; m_x = sx[g]; m_y = sy[g]; m_c = sc[g];
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            total++;
            if ({plot, x, y, colour, drop_count} !== {exp_plot, m_x, m_y, m_c, 8'(m_drop)}) begin
                bad++; $display("FAIL rand_out %0d: plot=%b x=%0d y=%0d c=%0d drop=%0d want %b/%0d/%0d/%0d/%0d",
                                n, plot, x, y, colour, drop_count, exp_plot, m_x, m_y, m_c, m_drop);
            end
            prev_v = v;
        end
        apply(4'h0);
    endtask

    task automatic test_drop();
        do_reset();
        sx[0] = 9'd320; sy[0] = 8'd10; sc[0] = 3'd7;
        apply(4'b0001);
        tick();
        apply(4'b0000);
        total++;
        if ({plot, drop_count} !== {1'b0, 8'd1}) begin
            bad++; $display("FAIL drop_x320: plot=%b drop=%0d want 0/1", plot, drop_count);
        end
        sx[0] = 9'd5; sy[0] = 8'd254;
        apply(4'b0001);
        tick();
        apply(4'b0000);
        total++;
        if ({plot, drop_count} !== {1'b0, 8'd2}) begin
            bad++; $display("FAIL drop_y254: plot=%b drop=%0d want 0/2", plot, drop_count);
        end
        for (int n = 0; n < 300; n++) begin
            sx[0] = 9'(320 + n % 100); sy[0] = 8'($urandom);
            apply(4'b0001);
            tick();
        end
        apply(4'b0000);
        total++;
        if ({plot, drop_count} !== {1'b0, 8'd255}) begin
            bad++; $display("FAIL drop_saturate: plot=%b drop=%0d want 0/255", plot, drop_count);
        end
        m_rr = 0;
    endtask

    task automatic test_clear();
        int g, nerr, first;
        for (int i = 0; i < 4; i++) begin
            sx[i] = 9'($urandom_range(0, 319)); sy[i] = 8'($urandom_range(0, 239)); sc[i] = 3'($urandom_range(1, 7));
        end
        apply(4'hF);
        clear_req = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0) begin
            bad++; $display("FAIL clear_req_ready: got %b want 0000", req_ready);
        end
        tick();
        nerr = 0; first = -1;
        for (int k = 0; k < 76800; k++) begin
            if (plot !== 1'b1 || x !== 9'(k % 320) || y !== 8'(k / 320) || colour !== 3'b000 ||
                busy !== 1'b1 || req_ready !== 4'b0 || clear_done !== 1'b0) begin
                nerr++;
                if (first < 0) first = k;
            end
            clear_req = (k == 500);
            tick();
        end
        total++;
        if (nerr !== 0) begin
            bad++; $display("FAIL clear_sweep: %0d bad pixels (first at %0d), want 0", nerr, first);
        end
        total++;
        if ({clear_done, busy, plot} !== 3'b100) begin
            bad++; $display("FAIL clear_done: done=%b busy=%b plot=%b want 1/0/0", clear_done, busy, plot);
        end
        g = model_grant(4'hF, m_rr);
        total++;
        if (req_ready !== onehot(g)) begin
            bad++; $display("FAIL clear_resume_grant: got %b want %b", req_ready, onehot(g));
        end
        tick();
        apply(4'h0);
        total++;
        if ({clear_done, plot, x, y, colour} !== {1'b0, 1'b1, sx[g], sy[g], sc[g]}) begin
            bad++; $display("FAIL clear_resume_plot: done=%b plot=%b x=%0d y=%0d c=%0d want 0/1/%0d/%0d/%0d",
                            clear_done, plot, x, y, colour, sx[g], sy[g], sc[g]);
        end
        m_rr = g;
    endtask

    task automatic test_reset_mid_clear();
        int g, ndone;
        apply(4'hF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 1000; k++) tick();
        total++;
        if ({x, y, busy} !== {9'd40, 8'd3, 1'b1}) begin
            bad++; $display("FAIL midclear_pos: x=%0d y=%0d busy=%b want 40/3/1", x, y, busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({plot, busy, x, y, req_ready} !== '0) begin
            bad++; $display("FAIL midclear_reset: plot=%b busy=%b x=%0d y=%0d ready=%b want all 0",
                            plot, busy, x, y, req_ready);
        end
        tick();
        reset = 1'b0;
        m_rr = 0;
        ndone = 0;
        for (int n = 0; n < 6; n++) begin
            #1;
            g = model_grant(4'hF, m_rr);
            total++;
            if (req_ready !== onehot(g)) begin
                bad++; $display("FAIL postreset_grant %0d: got %b want %b", n, req_ready, onehot(g));
            end
            if (clear_done !== 1'b0) ndone++;
            tick();
            if (clear_done !== 1'b0) ndone++;
            total++;
            if ({plot, x, y} !== {1'b1, sx[g], sy[g]}) begin
                bad++; $display("FAIL postreset_plot %0d: plot=%b x=%0d y=%0d want 1/%0d/%0d", n, plot, x, y, sx[g], sy[g]);
            end
            m_rr = g;
        end
        apply(4'h0);
        total++;
        if (ndone !== 0) begin
            bad++; $display("FAIL postreset_no_done: %0d clear_done cycles, want 0", ndone);
        end
    endtask

    initial begin
        req_valid = '0; req_x = '0; req_y = '0; req_colour = '0; clear_req = 1'b0; reset = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_drop();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
